// File: rtl/pc_unit_if.sv
// Bundle of the PC unit's control, vector-fetch and status signals.
// The core (slave) consumes control and vector data; the master side drives them.
interface pc_unit_if #(
   parameter int ADDR_W = 32
);
   logic              pc_en;
   logic              inst_len;
   logic              branch_taken;
   logic [ADDR_W-1:0] branch_addr;
   logic              int_req;
   logic              vec_ack;
   logic [ADDR_W-1:0] vec_data;
   logic              vec_req;
   logic [ADDR_W-1:0] vec_addr;
   logic [ADDR_W-1:0] pc;
   logic              pc_valid;
   logic [ADDR_W-1:0] ret_addr;
   logic              int_ack;

   modport master (
      output pc_en, inst_len, branch_taken, branch_addr, int_req, vec_ack, vec_data,
      input  vec_req, vec_addr, pc, pc_valid, ret_addr, int_ack
   );

   modport slave (
      input  pc_en, inst_len, branch_taken, branch_addr, int_req, vec_ack, vec_data,
      output vec_req, vec_addr, pc, pc_valid, ret_addr, int_ack
   );
endinterface

// File: rtl/pc_unit.sv
// Program counter with reset/interrupt vector fetch, branch redirect and a
// sticky interrupt-pending latch that is serviced on the next enabled RUN cycle.
module pc_unit #(
   parameter int                ADDR_W         = 32,
   parameter logic [ADDR_W-1:0] RESET_PC       = ADDR_W'(32'h20),
   parameter logic [ADDR_W-1:0] RESET_VEC_ADDR = ADDR_W'(0),
   parameter logic [ADDR_W-1:0] INT_VEC_ADDR   = ADDR_W'(1)
) (
   input logic        clk,
   input logic        rst,
   pc_unit_if.slave   bus
);
   localparam logic [1:0] VEC_RST = 2'd0;
   localparam logic [1:0] RUN     = 2'd1;
   localparam logic [1:0] VEC_INT = 2'd2;

   logic [1:0]        state;
   logic              pending;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] ret_q;
   logic [ADDR_W-1:0] seq_pc;
   logic [ADDR_W-1:0] next_pc;
   logic              take_int;

   // The address the PC would load if no interrupt intervened; also the return address.
   assign seq_pc   = pc_q + ADDR_W'(1) + ADDR_W'(bus.inst_len);
   assign next_pc  = bus.branch_taken ? bus.branch_addr : seq_pc;
   assign take_int = !rst && (state == RUN) && bus.pc_en && pending;

   assign bus.pc       = pc_q;
   assign bus.ret_addr = ret_q;
   assign bus.int_ack  = take_int;

   always_comb begin
      // NOTE: every output gets a default before the case so no path infers a latch.
      bus.vec_req  = 1'b0;
      bus.vec_addr = '0;
      bus.pc_valid = 1'b0;
      case (state)
         VEC_RST: begin
            bus.vec_req  = 1'b1;
            bus.vec_addr = RESET_VEC_ADDR;
         end
         VEC_INT: begin
            bus.vec_req  = 1'b1;
            bus.vec_addr = INT_VEC_ADDR;
         end
         RUN:     bus.pc_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state   <= VEC_RST;
         pc_q    <= RESET_PC;
         ret_q   <= '0;
         pending <= 1'b0;
      end else begin
         // A request in the servicing cycle survives as a fresh pending interrupt.
         pending <= (pending && !take_int) || bus.int_req;
         case (state)
            VEC_RST, VEC_INT: begin
               if (bus.vec_ack) begin
                  pc_q  <= bus.vec_data;
                  state <= RUN;
               end
            end
            RUN: begin
               if (bus.pc_en) begin
                  if (pending) begin
                     ret_q <= next_pc;
                     state <= VEC_INT;
                  end else begin
                     pc_q <= next_pc;
                  end
               end
            end
            default: state <= VEC_RST;
         endcase
      end
   end
endmodule

// File: tb/tb_pc_unit.sv
// Cycle-by-cycle vector bench for pc_unit: each record drives one cycle and
// carries the outputs expected while that cycle's inputs are applied.
module tb_pc_unit;
   typedef struct {
      logic        rst;
      logic        en;
      logic        len;
      logic        br;
      logic [31:0] baddr;
      logic        irq;
      logic        ack;
      logic [31:0] vdata;
      logic [31:0] e_pc;
      logic        e_valid;
      logic        e_vreq;
      logic [31:0] e_vaddr;
      logic [31:0] e_ret;
      logic        e_iack;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   cur_step = 0;
   vec_t exp_q[$];
   vec_t tbl[$];

   pc_unit_if #(.ADDR_W(32)) b ();

   pc_unit #(.ADDR_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (b)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(
      input logic [31:0] r, en, ln, br, ba, irq, ack, vd,
      input logic [31:0] epc, ev, evr, eva, er, ei
   );
      vec_t v;
      v.rst = r[0];    v.en = en[0];   v.len = ln[0];  v.br = br[0];
      v.baddr = ba;    v.irq = irq[0]; v.ack = ack[0]; v.vdata = vd;
      v.e_pc = epc;    v.e_valid = ev[0]; v.e_vreq = evr[0];
      v.e_vaddr = eva; v.e_ret = er;   v.e_iack = ei[0];
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL step %0d %s: got 0x%08h expected 0x%08h", cur_step, name, act, exp);
      end
   endtask

   task automatic step(input vec_t v);
      vec_t e;
      @(negedge clk);
      rst            = v.rst;
      b.pc_en        = v.en;
      b.inst_len     = v.len;
      b.branch_taken = v.br;
      b.branch_addr  = v.baddr;
      b.int_req      = v.irq;
      b.vec_ack      = v.ack;
      b.vec_data     = v.vdata;
      exp_q.push_back(v);
      #2;
      e = exp_q.pop_front();
      check("pc",       b.pc,               e.e_pc);
      check("pc_valid", 32'(b.pc_valid),    32'(e.e_valid));
      check("vec_req",  32'(b.vec_req),     32'(e.e_vreq));
      check("vec_addr", b.vec_addr,         e.e_vaddr);
      check("ret_addr", b.ret_addr,         e.e_ret);
      check("int_ack",  32'(b.int_ack),     32'(e.e_iack));
      cur_step++;
   endtask

   initial begin
      rst = 1'b1;
      b.pc_en = 1'b0; b.inst_len = 1'b0; b.branch_taken = 1'b0; b.branch_addr = '0;
      b.int_req = 1'b0; b.vec_ack = 1'b0; b.vec_data = '0;
      @(negedge clk);
      @(negedge clk);

      // rst en len br baddr irq ack vdata | pc valid vreq vaddr ret iack
      // Reset boot: three cycles of vector request, ack on the third.
      tbl.push_back(mk(0,0,0,0,0,0,0,32'hDEAD,       32'h20,0,1,0,0,0));
      tbl.push_back(mk(0,1,0,0,0,0,0,0,              32'h20,0,1,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,1,32'h100,        32'h20,0,1,0,0,0));
      // Sequencing and stall; stray vec_ack in RUN is ignored.
      tbl.push_back(mk(0,1,0,0,0,0,0,0,              32'h100,1,0,0,0,0));
      tbl.push_back(mk(0,1,1,0,0,0,0,0,              32'h101,1,0,0,0,0));
      tbl.push_back(mk(0,1,0,0,0,0,0,0,              32'h103,1,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,1,32'h999,        32'h104,1,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,              32'h104,1,0,0,0,0));
      tbl.push_back(mk(0,1,0,1,32'h200,0,0,0,        32'h104,1,0,0,0,0));
      // Branch and interrupt together; second request in the taking cycle stays pending.
      tbl.push_back(mk(0,0,0,0,0,1,0,0,              32'h200,1,0,0,0,0));
      tbl.push_back(mk(0,1,0,1,32'h300,1,0,0,        32'h200,1,0,0,0,1));
      tbl.push_back(mk(0,1,0,0,0,0,0,0,              32'h200,0,1,1,32'h300,0));
      tbl.push_back(mk(0,0,0,0,0,0,1,32'h50,         32'h200,0,1,1,32'h300,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,              32'h50,1,0,0,32'h300,0));
      tbl.push_back(mk(0,1,0,0,0,0,0,0,              32'h50,1,0,0,32'h300,1));
      tbl.push_back(mk(0,0,0,0,0,0,1,32'h400,        32'h50,0,1,1,32'h51,0));
      // Interrupt pulse during a four-cycle stall.
      tbl.push_back(mk(0,0,0,0,0,1,0,0,              32'h400,1,0,0,32'h51,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,              32'h400,1,0,0,32'h51,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,              32'h400,1,0,0,32'h51,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,              32'h400,1,0,0,32'h51,0));
      tbl.push_back(mk(0,1,1,0,0,0,0,0,              32'h400,1,0,0,32'h51,1));
      tbl.push_back(mk(0,0,0,0,0,0,1,32'hFFFFFFFF,   32'h400,0,1,1,32'h402,0));
      // Wrap-around of the sequential increment.
      tbl.push_back(mk(0,1,1,0,0,0,0,0,              32'hFFFFFFFF,1,0,0,32'h402,0));
      tbl.push_back(mk(0,1,0,0,0,0,0,0,              32'h1,1,0,0,32'h402,0));
      tbl.push_back(mk(0,1,0,1,32'hFFFFFFFF,0,0,0,   32'h2,1,0,0,32'h402,0));
      tbl.push_back(mk(0,1,0,0,0,0,0,0,              32'hFFFFFFFF,1,0,0,32'h402,0));
      tbl.push_back(mk(0,0,0,0,0,1,0,0,              32'h0,1,0,0,32'h402,0));
      tbl.push_back(mk(0,1,0,0,0,0,0,0,              32'h0,1,0,0,32'h402,1));
      // Reset during VEC_INT with same-cycle vec_ack and int_req.
      tbl.push_back(mk(1,0,0,0,0,1,1,32'h777,        32'h0,0,1,1,32'h1,0));
      tbl.push_back(mk(0,1,0,0,0,0,0,0,              32'h20,0,1,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,1,32'h600,        32'h20,0,1,0,0,0));
      tbl.push_back(mk(0,1,0,0,0,1,0,0,              32'h600,1,0,0,0,0));
      // Reset in RUN with a pending interrupt: no ack, and pending is dropped.
      tbl.push_back(mk(1,1,0,0,0,0,0,0,              32'h601,1,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,              32'h20,0,1,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,1,32'h700,        32'h20,0,1,0,0,0));
      tbl.push_back(mk(0,1,0,0,0,0,0,0,              32'h700,1,0,0,0,0));

      foreach (tbl[i]) step(tbl[i]);

      // Long reset-vector latency with an interrupt arriving during the fetch.
      step(mk(1,0,0,0,0,0,0,0,                       32'h701,1,0,0,0,0));
      for (int i = 0; i < 20; i++)
         step(mk(0,i%2,0,0,0,(i==5)?1:0,0,$urandom,  32'h20,0,1,0,0,0));
      step(mk(0,0,0,0,0,0,1,32'h800,                 32'h20,0,1,0,0,0));
      step(mk(0,1,1,0,0,0,0,0,                       32'h800,1,0,0,0,1));
      step(mk(0,0,0,0,0,0,1,32'h900,                 32'h800,0,1,1,32'h802,0));
      step(mk(0,1,0,0,0,0,0,0,                       32'h900,1,0,0,32'h802,0));
      step(mk(0,0,0,0,0,0,0,0,                       32'h901,1,0,0,32'h802,0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
